polar_ubit_collector: RTL

Downstream stage of the 2-bit leaf (P-node) decoder. It takes one decoded bit pair per cycle (u1, u2 with their frozen flags) and does two things:
- returns the registered partial sums (beta) to the upstream g-function stage;
- packs the non-frozen (information) bits, in decode order, into a K-bit result register.

It raises a one-cycle done pulse when the programmed number of information bits has been collected, and flags any excess information bits.

---
 rtl/polar_ubit_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/polar_ubit_collector.sv
// polar_ubit_collector: receives decoded bit pairs from the 2-bit leaf decoder.
// It returns registered partial sums (beta) to the upstream g-function stage.
// It also packs the information (non-frozen) bits, in decode order, into a
// K_MAX-wide result register. A one-cycle done pulse fires when k bits are collected.
module polar_ubit_collector #(
  parameter int K_MAX = 140,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] k_in,
  input  logic             pair_valid,
  input  logic             u1,
  input  logic             u2,
  input  logic             frozen_1,
  input  logic             frozen_2,
  output logic             beta_valid,
  output logic             beta_0,
  output logic             beta_1,
  output logic             busy,
  output logic [K_MAX-1:0] dec_bits,
  output logic             dec_valid,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] k_reg_q, k_reg_d;
  logic [K_MAX-1:0] dec_bits_q, dec_bits_d;
  logic             overflow_q, overflow_d;
  logic             dec_valid_q, dec_valid_d;
  logic             busy_q, busy_d;
  logic             beta_valid_q, beta_valid_d;
  logic             beta_0_q, beta_0_d;
  logic             beta_1_q, beta_1_d;
  logic [CNT_W-1:0] k_clamped;

  // Requested k is limited to the width of the result register
  assign k_clamped = (k_in > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_in;

  // Register stage: every output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      k_reg_q      <= '0;
      dec_bits_q   <= '0;
      overflow_q   <= 1'b0;
      dec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      beta_valid_q <= 1'b0;
      beta_0_q     <= 1'b0;
      beta_1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      k_reg_q      <= k_reg_d;
      dec_bits_q   <= dec_bits_d;
      overflow_q   <= overflow_d;
      dec_valid_q  <= dec_valid_d;
      busy_q       <= busy_d;
      beta_valid_q <= beta_valid_d;
      beta_0_q     <= beta_0_d;
      beta_1_q     <= beta_1_d;
    end
  end

  // Next-state and datapath: start has priority over pairs; u1 is processed before u2
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    k_reg_d      = k_reg_q;
    dec_bits_d   = dec_bits_q;
    overflow_d   = overflow_q;
    dec_valid_d  = 1'b0;
    beta_valid_d = 1'b0;
    beta_0_d     = 1'b0;
    beta_1_d     = 1'b0;

    if (start) begin
      state_d     = (k_clamped == '0) ? S_DONE : S_COLLECT;
      wr_ptr_d    = '0;
      dec_bits_d  = '0;
      overflow_d  = 1'b0;
      k_reg_d     = k_clamped;
      dec_valid_d = (k_clamped == '0);
    end else if (pair_valid && (state_q != S_IDLE)) begin
      beta_valid_d = 1'b1;
      beta_0_d     = u1 ^ u2;
      beta_1_d     = u2;
      if (state_q == S_COLLECT) begin
        if (!frozen_1) begin
          if (wr_ptr_d < k_reg_q) begin
            dec_bits_d = dec_bits_d | ({{(K_MAX-1){1'b0}}, u1} << wr_ptr_d);
            wr_ptr_d   = wr_ptr_d + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!frozen_2) begin
          if (wr_ptr_d < k_reg_q) begin
            dec_bits_d = dec_bits_d | ({{(K_MAX-1){1'b0}}, u2} << wr_ptr_d);
            wr_ptr_d   = wr_ptr_d + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (wr_ptr_d == k_reg_q) begin
          state_d     = S_DONE;
          dec_valid_d = 1'b1;
        end
      end else if (!frozen_1 || !frozen_2) begin
        overflow_d = 1'b1;
      end
    end

    busy_d = (state_d == S_COLLECT);
  end

  assign beta_valid = beta_valid_q;
  assign beta_0     = beta_0_q;
  assign beta_1     = beta_1_q;
  assign busy       = busy_q;
  assign dec_bits   = dec_bits_q;
  assign dec_valid  = dec_valid_q;
  assign overflow   = overflow_q;

endmodule
